frame_stream_sequencer: RTL and testbench

Pixel-stream master for the thinning/corner pipeline. Holds one N×N frame in an internal buffer and broadcasts it pixel by pixel to the kernelRam-style convolution units over the shared `we`/address/data bus. It then runs a read-out sweep with `we` low, captures each unit's `primary_output`/`harris_bit` result back into the buffer, and repeats passes until the image stops changing or a pass limit is reached.

---
 rtl/skel_pkg.sv | 24 ++
 rtl/frame_buffer.sv | 36 +++
 rtl/frame_stream_sequencer.sv | 172 +++++++++++++++++
 tb/tb_frame_stream_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/skel_pkg.sv
// Shared types and constants for the frame stream sequencer and the kernel units it drives.
package skel_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE_PASS,
    READ_PASS,
    CHECK,
    DONE
  } seq_state_t;

  function automatic int unsigned frame_pixels(input int unsigned side);
    return side * side;
  endfunction

  localparam int unsigned FRAME_SIDE   = 8;
  localparam int unsigned FRAME_PIXELS = frame_pixels(FRAME_SIDE);
  localparam int unsigned ADDR_W       = 7;
  localparam int unsigned PIXEL_W      = 8;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [PIXEL_W-1:0] pixel_t;

endpackage

// File: rtl/frame_buffer.sv
// Frame RAM: one write port, two registered read ports (stream and host) with write-first bypass.
module frame_buffer #(
  parameter int unsigned AW = 7,
  parameter int unsigned PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [PW-1:0] wdata,
  input  logic [AW-1:0] s_addr,
  output logic [PW-1:0] s_data,
  input  logic [AW-1:0] h_addr,
  output logic [PW-1:0] h_data
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [PW-1:0] mem [DEPTH];

  // Contents survive reset so a partially processed frame stays readable.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_data <= '0;
      h_data <= '0;
    end else begin
      s_data <= (we && (waddr == s_addr)) ? wdata : mem[s_addr];
      h_data <= (we && (waddr == h_addr)) ? wdata : mem[h_addr];
    end
  end

endmodule

// File: rtl/frame_stream_sequencer.sv
// Broadcasts a buffered frame to the kernel units, captures their results, and iterates until stable.
module frame_stream_sequencer
  import skel_pkg::*;
#(
  parameter int unsigned N          = 8,
  parameter int unsigned bitSize    = 6,
  parameter int unsigned pixelWidth = 8,
  parameter int unsigned MAX_PASSES = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            load_we,
  input  logic [bitSize:0]                load_addr,
  input  logic [pixelWidth-1:0]           load_data,
  input  logic [bitSize:0]                rd_addr,
  output logic [pixelWidth-1:0]           rd_data,
  output logic                            stream_we,
  output logic [bitSize:0]                stream_addr,
  output logic [pixelWidth-1:0]           stream_data,
  input  logic [pixelWidth-1:0]           result_pixel,
  input  logic                            result_harris,
  output logic                            busy,
  output logic                            done,
  output logic [$clog2(MAX_PASSES+1)-1:0] pass_count,
  output logic [bitSize+1:0]              corner_count
);

  localparam int unsigned AW     = bitSize + 1;
  localparam int unsigned PW     = pixelWidth;
  localparam int unsigned PCW    = $clog2(MAX_PASSES + 1);
  localparam int unsigned CCW    = bitSize + 2;
  localparam int unsigned PIXELS = frame_pixels(N);
  localparam logic [AW-1:0] LAST_ADDR = AW'(PIXELS - 1);

  seq_state_t     state_q, state_d;
  logic [AW-1:0]  addr_q, addr_d, addr_inc;
  logic           phase_q, phase_d;
  logic           changed_q, changed_d;
  logic [CCW-1:0] acc_q, acc_d;
  logic [PCW-1:0] pass_q, pass_d;
  logic [CCW-1:0] corner_q, corner_d;
  logic           we_q, busy_q, done_q;

  logic           buf_we;
  logic [AW-1:0]  buf_waddr;
  logic [PW-1:0]  buf_wdata;
  logic [PW-1:0]  stream_pix;

  // Stream port reads the upcoming address so its data lines up with the registered bus address.
  frame_buffer #(
    .AW(AW),
    .PW(PW)
  ) u_frame_buffer (
    .clk    (clk),
    .rst    (rst),
    .we     (buf_we),
    .waddr  (buf_waddr),
    .wdata  (buf_wdata),
    .s_addr (addr_d),
    .s_data (stream_pix),
    .h_addr (rd_addr),
    .h_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      phase_q   <= 1'b0;
      changed_q <= 1'b0;
      acc_q     <= '0;
      pass_q    <= '0;
      corner_q  <= '0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      phase_q   <= phase_d;
      changed_q <= changed_d;
      acc_q     <= acc_d;
      pass_q    <= pass_d;
      corner_q  <= corner_d;
      we_q      <= (state_d == WRITE_PASS);
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == DONE);
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    phase_d   = phase_q;
    changed_d = changed_q;
    acc_d     = acc_q;
    pass_d    = pass_q;
    corner_d  = corner_q;
    buf_we    = 1'b0;
    buf_waddr = load_addr;
    buf_wdata = load_data;
    addr_inc  = (addr_q == LAST_ADDR) ? addr_q : addr_q + AW'(1);

    case (state_q)
      IDLE: begin
        addr_d  = '0;
        phase_d = 1'b0;
        buf_we  = load_we;
        if (start) begin
          state_d  = WRITE_PASS;
          pass_d   = '0;
          corner_d = '0;
        end
      end

      WRITE_PASS: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          if (addr_q == LAST_ADDR) begin
            state_d   = READ_PASS;
            addr_d    = '0;
            changed_d = 1'b0;
            acc_d     = '0;
          end else begin
            addr_d = addr_inc;
          end
        end
      end

      // Results are valid on the second cycle of each beat; capture and compare then.
      READ_PASS: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          buf_we    = 1'b1;
          buf_waddr = addr_q;
          buf_wdata = result_pixel;
          if (result_pixel != stream_pix) changed_d = 1'b1;
          if (result_harris) acc_d = acc_q + CCW'(1);
          if (addr_q == LAST_ADDR) begin
            state_d  = CHECK;
            addr_d   = '0;
            pass_d   = pass_q + PCW'(1);
            corner_d = acc_d;
          end else begin
            addr_d = addr_inc;
          end
        end
      end

      CHECK: begin
        addr_d  = '0;
        phase_d = 1'b0;
        if (!changed_q || (pass_q == PCW'(MAX_PASSES))) state_d = DONE;
        else state_d = WRITE_PASS;
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  assign stream_we    = we_q;
  assign stream_addr  = addr_q;
  assign stream_data  = stream_pix;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass_count   = pass_q;
  assign corner_count = corner_q;

endmodule

// File: tb/tb_frame_stream_sequencer.sv
// Directed bench for frame_stream_sequencer with a behavioural kernel-unit stub.
module tb_frame_stream_sequencer;
  import skel_pkg::*;

  localparam int unsigned N    = FRAME_SIDE;
  localparam int unsigned AW   = ADDR_W;
  localparam int unsigned PW   = PIXEL_W;
  localparam int unsigned PCW  = 4;
  localparam int unsigned CCW  = 8;
  localparam int          ITER = 4 * N * N + 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           load_we;
  addr_t          load_addr;
  pixel_t         load_data;
  addr_t          rd_addr;
  pixel_t         rd_data;
  logic           stream_we;
  addr_t          stream_addr;
  pixel_t         stream_data;
  pixel_t         result_pixel;
  logic           result_harris;
  logic           busy;
  logic           done;
  logic [PCW-1:0] pass_count;
  logic [CCW-1:0] corner_count;

  int errors = 0;
  int checks = 0;

  pixel_t kmem [0:127];
  logic   invert = 1'b0;
  logic   harris_mode = 1'b0;

  frame_stream_sequencer #(
    .N(8), .bitSize(6), .pixelWidth(8), .MAX_PASSES(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .load_we(load_we),
    .load_addr(load_addr), .load_data(load_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .stream_we(stream_we), .stream_addr(stream_addr), .stream_data(stream_data),
    .result_pixel(result_pixel), .result_harris(result_harris),
    .busy(busy), .done(done), .pass_count(pass_count), .corner_count(corner_count)
  );

  always #5 clk = ~clk;

  // Kernel stub: latches broadcast pixels, returns them (optionally inverted).
  always @(posedge clk) if (stream_we) kmem[stream_addr] <= stream_data;
  assign result_pixel  = invert ? ~kmem[stream_addr] : kmem[stream_addr];
  assign result_harris = harris_mode && ((int'(stream_addr) % 3) == 0);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_frame();
    for (int i = 0; i < int'(N * N); i++) begin
      load_we   = 1'b1;
      load_addr = AW'(i);
      load_data = PW'(i);
      tick();
    end
    load_we = 1'b0;
  endtask

  task automatic read_pix(input int a, output pixel_t v);
    rd_addr = AW'(a);
    tick();
    v = rd_data;
  endtask

  task automatic start_and_wait(output int lat);
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1;
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      if (done === 1'b1) begin
        lat = cyc;
        break;
      end
      tick();
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b want=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b want=0", done); end
    checks++; if (stream_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%0b want=0", stream_we); end
    checks++; if (stream_addr !== 7'd0) begin errors++; $display("FAIL reset_addr got=%0d want=0", stream_addr); end
    checks++; if (stream_data !== 8'd0) begin errors++; $display("FAIL reset_data got=%0h want=0", stream_data); end
    checks++; if (pass_count !== 4'd0) begin errors++; $display("FAIL reset_pass got=%0d want=0", pass_count); end
    checks++; if (corner_count !== 8'd0) begin errors++; $display("FAIL reset_corner got=%0d want=0", corner_count); end
    checks++; if (rd_data !== 8'd0) begin errors++; $display("FAIL reset_rd got=%0h want=0", rd_data); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_stream_order();
    int lat;
    int ea;
    logic ew;
    pixel_t v;
    load_frame();
    invert = 1'b0;
    harris_mode = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL order_busy_rise got=%0b want=1", busy); end
    for (int cyc = 1; cyc <= 400; cyc++) begin
      if (cyc <= 256) begin
        ew = (cyc <= 128);
        ea = ew ? (cyc - 1) / 2 : (cyc - 129) / 2;
        checks++;
        if (stream_addr !== AW'(ea) || stream_we !== ew || (ew && stream_data !== PW'(ea))) begin
          errors++;
          $display("FAIL order_bus cyc=%0d got addr=%0d we=%0b data=%0h want addr=%0d we=%0b data=%0h",
                   cyc, stream_addr, stream_we, stream_data, ea, ew, ea);
        end
      end
      if (done === 1'b1) begin
        lat = cyc;
        break;
      end
      tick();
    end
    checks++; if (lat != ITER + 1) begin errors++; $display("FAIL order_done_latency got=%0d want=%0d", lat, ITER + 1); end
    checks++; if (pass_count !== 4'd1) begin errors++; $display("FAIL order_pass got=%0d want=1", pass_count); end
    checks++; if (corner_count !== 8'd0) begin errors++; $display("FAIL order_corner got=%0d want=0", corner_count); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL order_busy_fall got=%0b want=0", busy); end
    read_pix(7, v);
    checks++; if (v !== 8'd7) begin errors++; $display("FAIL order_readback got=%0h want=07", v); end
  endtask

  task automatic test_same_cycle_load_start();
    int lat;
    invert = 1'b0;
    load_we   = 1'b1;
    load_addr = 7'd0;
    load_data = 8'hAA;
    start     = 1'b1;
    tick();
    load_we = 1'b0;
    start   = 1'b0;
    checks++; if (stream_we !== 1'b1 || stream_addr !== 7'd0 || stream_data !== 8'hAA) begin
      errors++;
      $display("FAIL same_cycle_first_beat got we=%0b addr=%0d data=%0h want we=1 addr=0 data=aa",
               stream_we, stream_addr, stream_data);
    end
    lat = -1;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      if (done === 1'b1) begin lat = cyc; break; end
      tick();
    end
    checks++; if (lat != ITER + 1) begin errors++; $display("FAIL same_cycle_latency got=%0d want=%0d", lat, ITER + 1); end
    tick();
    load_we = 1'b1; load_addr = 7'd0; load_data = 8'h00;
    tick();
    load_we = 1'b0;
  endtask

  task automatic test_pass_limit();
    int lat;
    pixel_t v;
    invert = 1'b1;
    start_and_wait(lat);
    checks++; if (lat != 8 * ITER + 1) begin errors++; $display("FAIL limit_latency got=%0d want=%0d", lat, 8 * ITER + 1); end
    checks++; if (pass_count !== 4'd8) begin errors++; $display("FAIL limit_pass got=%0d want=8", pass_count); end
    read_pix(5, v);
    checks++; if (v !== 8'd5) begin errors++; $display("FAIL limit_readback got=%0h want=05", v); end
    invert = 1'b0;
  endtask

  task automatic test_corner_count();
    int lat;
    harris_mode = 1'b1;
    start_and_wait(lat);
    checks++; if (lat != ITER + 1) begin errors++; $display("FAIL corner_latency got=%0d want=%0d", lat, ITER + 1); end
    checks++; if (corner_count !== 8'd22) begin errors++; $display("FAIL corner_count got=%0d want=22", corner_count); end
    checks++; if (pass_count !== 4'd1) begin errors++; $display("FAIL corner_pass got=%0d want=1", pass_count); end
    harris_mode = 1'b0;
  endtask

  task automatic test_busy_rules();
    int lat;
    pixel_t v;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      if (cyc >= 140 && cyc < 144) begin
        start = 1'b1; load_we = 1'b1; load_addr = 7'd0; load_data = 8'hFF;
      end else begin
        start = 1'b0; load_we = 1'b0;
      end
      if (done === 1'b1) begin lat = cyc; break; end
      tick();
    end
    start = 1'b0; load_we = 1'b0;
    checks++; if (lat != ITER + 1) begin errors++; $display("FAIL busy_latency got=%0d want=%0d", lat, ITER + 1); end
    repeat (3) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_no_restart got=%0b want=0", busy); end
    read_pix(0, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL busy_frame0 got=%0h want=00", v); end
  endtask

  task automatic test_mid_reset();
    int lat;
    pixel_t v;
    invert = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (149) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%0b want=0", busy); end
    checks++; if (stream_we !== 1'b0) begin errors++; $display("FAIL midrst_we got=%0b want=0", stream_we); end
    checks++; if (pass_count !== 4'd0) begin errors++; $display("FAIL midrst_pass got=%0d want=0", pass_count); end
    checks++; if (stream_addr !== 7'd0) begin errors++; $display("FAIL midrst_addr got=%0d want=0", stream_addr); end
    for (int i = 0; i <= 11; i++) begin
      pixel_t exp_v;
      exp_v = (i <= 10) ? ~PW'(i) : PW'(i);
      read_pix(i, v);
      checks++; if (v !== exp_v) begin errors++; $display("FAIL midrst_frame addr=%0d got=%0h want=%0h", i, v, exp_v); end
    end
    invert = 1'b0;
    start_and_wait(lat);
    checks++; if (lat != ITER + 1) begin errors++; $display("FAIL midrst_restart_latency got=%0d want=%0d", lat, ITER + 1); end
    checks++; if (pass_count !== 4'd1) begin errors++; $display("FAIL midrst_restart_pass got=%0d want=1", pass_count); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; load_we = 1'b0;
    load_addr = '0; load_data = '0; rd_addr = '0;
    test_reset();
    test_stream_order();
    test_same_cycle_load_start();
    test_pass_limit();
    test_corner_count();
    test_busy_rules();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
